// File: rtl/mips_divider.sv
// mips_divider: multicycle restoring divider for MIPS DIV/DIVU.
// One quotient bit is resolved per clock in CALC (32 steps). Operands are turned
// into magnitudes on acceptance, and signs are fixed up on the edge leaving CALC.
// A zero divisor bypasses CALC and produces the MIPS-style all-ones quotient.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           request a division (accepted only while busy=0)
//   is_signed       1 = DIV (two's complement), 0 = DIVU
//   dividend        numerator, sampled with start
//   divisor         denominator, sampled with start
//   busy            high whenever the FSM is not idle
//   done            one-cycle pulse, results valid
//   quotient        LO result, held until the next accepted start
//   remainder       HI result, held until the next accepted start
//   div_by_zero     divisor was zero, held with the results
module mips_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;       // partial remainder
    logic [W-1:0]   qw_q, qw_d;         // working quotient (starts as |dividend|)
    logic [W-1:0]   d_q, d_d;           // |divisor|
    logic [CW-1:0]  count_q, count_d;
    logic           is_signed_q, is_signed_d;
    logic           dvd_neg_q, dvd_neg_d;
    logic           dvs_neg_q, dvs_neg_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;

    // Magnitude only for signed operations; -0x80000000 stays 0x80000000 unsigned.
    function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic sgn);
        return (sgn && v[W-1]) ? W'(-v) : v;
    endfunction

    // One restoring step: shift {acc, q} left, trial-subtract the divisor.
    logic [W:0]   acc_sh;
    logic [W+1:0] trial;
    logic         trial_ok;
    logic [W-1:0] acc_nx;
    logic [W-1:0] qw_nx;

    always_comb begin
        acc_sh   = {acc_q, qw_q[W-1]};
        trial    = {1'b0, acc_sh} - {2'b00, d_q};
        trial_ok = ~trial[W+1];
        acc_nx   = trial_ok ? W'(trial) : acc_sh[W-1:0];
        qw_nx    = {qw_q[W-2:0], trial_ok};
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        qw_d        = qw_q;
        d_d         = d_q;
        count_d     = count_q;
        is_signed_d = is_signed_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        done_d      = 1'b0;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_signed_d = is_signed;
                    dvd_neg_d   = dividend[W-1];
                    dvs_neg_d   = divisor[W-1];
                    acc_d       = '0;
                    qw_d        = mag(dividend, is_signed);
                    d_d         = mag(divisor, is_signed);
                    count_d     = '0;
                    dbz_d       = 1'b0;
                    if (divisor == '0) begin
                        // Results are known now; DONE spends one cycle before pulsing done.
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d   = acc_nx;
                qw_d    = qw_nx;
                count_d = count_q + CW'(1);
                if (count_q == CW'(W - 1)) begin
                    quo_d   = (is_signed_q && (dvd_neg_q ^ dvs_neg_q)) ? W'(-qw_nx) : qw_nx;
                    rem_d   = (is_signed_q && dvd_neg_q) ? W'(-acc_nx) : acc_nx;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Leave once done has been pulsed; the zero-divisor path pulses here first.
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            qw_q        <= '0;
            d_q         <= '0;
            count_q     <= '0;
            is_signed_q <= 1'b0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            qw_q        <= qw_d;
            d_q         <= d_d;
            count_q     <= count_d;
            is_signed_q <= is_signed_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_divider.sv
// tb_mips_divider: directed test of mips_divider with hand-computed results,
// latency, hold behaviour, start-while-busy and asynchronous reset.
module tb_mips_divider;
    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    logic [31:0] prev_q = 32'h0;
    logic [31:0] prev_r = 32'h0;

    mips_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one division; inject > 0 pulses a 50/5 start that must be ignored,
    // sampled on edge N+inject.
    task automatic run_div(input string name, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq,
                           input logic [31:0] er, input logic edbz, input int inject);
        int lat;
        lat = (b == 32'h0) ? 1 : 32;
        @(negedge clk);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(posedge clk); #1;                 // edge N
        start = 1'b0;
        dividend = 32'hDEAD_BEEF; divisor = 32'h3;   // must not disturb the result
        chk({name, ":busy@N"}, {31'b0, busy}, 32'h1);
        chk({name, ":dbz@N"}, {31'b0, div_by_zero}, {31'b0, (b == 32'h0)});
        for (int k = 1; k <= lat; k++) begin
            if (inject > 0 && k == inject) begin
                @(negedge clk);
                start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
            end
            @(posedge clk); #1;             // edge N+k
            if (inject > 0 && k == inject) start = 1'b0;
            chk({name, ":done"}, {31'b0, done}, {31'b0, (k == lat)});
            chk({name, ":busy"}, {31'b0, busy}, 32'h1);
            if (lat == 32 && k < lat) begin
                chk({name, ":q_hold_calc"}, quotient, prev_q);
                chk({name, ":r_hold_calc"}, remainder, prev_r);
            end
        end
        chk({name, ":quotient"}, quotient, eq);
        chk({name, ":remainder"}, remainder, er);
        chk({name, ":dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
        @(posedge clk); #1;
        chk({name, ":done_low"}, {31'b0, done}, 32'h0);
        chk({name, ":busy_low"}, {31'b0, busy}, 32'h0);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        logic saw_done;
        rst = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst:busy", {31'b0, busy}, 32'h0);
        chk("rst:done", {31'b0, done}, 32'h0);
        chk("rst:quotient", quotient, 32'h0);
        chk("rst:remainder", remainder, 32'h0);
        chk("rst:dbz", {31'b0, div_by_zero}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        run_div("u100_7_busy",  1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 5);
        run_div("u50_5",        1'b0, 32'd50,        32'd5,         32'd10,        32'd0,         1'b0, 0);
        run_div("s_m7_2",       1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 0);
        run_div("u_fff9_2",     1'b0, 32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC,  32'd1,         1'b0, 0);
        run_div("dbz",          1'b0, 32'h12345678,  32'h0,         32'hFFFFFFFF,  32'h12345678,  1'b1, 0);

        // Results and the zero flag persist while idle.
        repeat (3) @(posedge clk);
        #1;
        chk("hold:quotient", quotient, 32'hFFFFFFFF);
        chk("hold:remainder", remainder, 32'h12345678);
        chk("hold:dbz", {31'b0, div_by_zero}, 32'h1);

        run_div("s_ovf",        1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h0,         1'b0, 0);
        run_div("s_7_m2",       1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0, 0);
        run_div("s_m100_m7",    1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0, 0);
        run_div("s_dbz_neg",    1'b1, 32'hFFFFFFFB,  32'h0,         32'hFFFFFFFF,  32'hFFFFFFFB,  1'b1, 0);

        // Reset in the middle of a calculation.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst:busy", {31'b0, busy}, 32'h0);
        chk("midrst:done", {31'b0, done}, 32'h0);
        chk("midrst:quotient", quotient, 32'h0);
        chk("midrst:remainder", remainder, 32'h0);
        chk("midrst:dbz", {31'b0, div_by_zero}, 32'h0);
        #1 rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk("midrst:no_done", {31'b0, saw_done}, 32'h0);
        prev_q = 32'h0;
        prev_r = 32'h0;

        run_div("u_ffff_1",     1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'h0,         1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_divider.md
MIPS_DIVIDER -- requirements
Module: mips_divider

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 The block SHALL expose these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a division; sampled only while busy=0.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  in  32  numerator (LO source); sampled with start.
- divisor  in  32  denominator; sampled with start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; results valid.
- quotient  out  32  result for LO.
- remainder  out  32  result for HI.
- div_by_zero  out  1  divisor was zero; valid with done, held with results.

Function
REQ-003 The FSM SHALL have three states, IDLE, CALC and DONE, and no others.
REQ-004 IDLE SHALL do the following:
- If start=1 at edge N, capture the operands and set is_signed_q.
- Load remainder accumulator = 0, quotient register = |dividend|, divisor register = |divisor|.
- Magnitudes are taken only when is_signed=1, as a 32-bit unsigned two's complement negation.
- Go to CALC with step count = 0.
REQ-005 If the divisor is zero at edge N, the block SHALL go directly to DONE at edge N and skip CALC.
REQ-006 CALC SHALL perform one restoring step per edge:
- Shift {acc, q} left by 1.
- Compute trial = acc - d at 33 bits.
- If trial is non-negative, set acc = trial and q[0] = 1; otherwise q[0] = 0.
- Increment the count.
REQ-007 After the 32nd step (edge N+32), CALC SHALL go to DONE and apply sign fix-up in the same edge:
- quotient is negated if is_signed_q=1 and the operand signs differ.
- remainder is negated if is_signed_q=1 and the dividend was negative.
REQ-008 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE on the next edge.
REQ-009 Latency: done SHALL be high in the cycle after edge N+32 for a nonzero divisor, and after edge N+1 for a zero divisor.
REQ-010 Divide by zero SHALL produce quotient = 0xFFFFFFFF, remainder = dividend, div_by_zero = 1.
REQ-011 Signed 0x80000000 / 0xFFFFFFFF SHALL produce quotient = 0x80000000, remainder = 0, div_by_zero = 0, with no trap.
REQ-012 start SHALL be ignored while busy=1; operand changes during CALC or DONE SHALL NOT affect the result.
REQ-013 quotient, remainder and div_by_zero SHALL hold their values from done until the next accepted start.
REQ-014 On the next accepted start, div_by_zero SHALL clear to 0 at that edge.
REQ-015 During CALC, quotient and remainder outputs SHALL NOT change.
REQ-016 Remainder magnitude SHALL always be strictly less than |divisor| when the divisor is nonzero.

Reset
REQ-017 rst=1 SHALL immediately, without waiting for a clock edge, force state = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, count = 0.
REQ-018 Reset during CALC or DONE SHALL abort the operation with no done pulse.
REQ-019 The first start after rst falls SHALL be accepted normally.

Verification
REQ-020 Unsigned case:
- Stimulus: start at N, is_signed=0, 100 / 7.
- Response: busy high from N to N+33; done only in cycle N+32..N+33; quotient = 14, remainder = 2.
REQ-021 Signed case:
- Stimulus: is_signed=1, 0xFFFFFFF9 (-7) / 2.
- Response: quotient = 0xFFFFFFFD (-3), remainder = 0xFFFFFFFF (-1).
- Stimulus: is_signed=0, same operands.
- Response: quotient = 0x7FFFFFFC, remainder = 1.
REQ-022 Divide by zero:
- Stimulus: dividend 0x12345678, divisor 0.
- Response: done in cycle N+1..N+2; quotient = 0xFFFFFFFF, remainder = 0x12345678, div_by_zero = 1.
REQ-023 Signed overflow:
- Stimulus: signed 0x80000000 / 0xFFFFFFFF.
- Response: quotient = 0x80000000, remainder = 0, div_by_zero = 0.
REQ-024 Start while busy:
- Stimulus: start at N+5 with 50 / 5.
- Response: ignored; the original 100 / 7 result returns.
- Stimulus: 50 / 5 started after done.
- Response: quotient = 10, remainder = 0.
REQ-025 Reset mid-operation:
- Stimulus: rst pulsed between edges N+10 and N+11.
- Response: busy, done and outputs are 0 immediately; no done pulse follows.
- Stimulus: a new 0xFFFFFFFF / 1 unsigned.
- Response: quotient = 0xFFFFFFFF, remainder = 0.
